mem_req_initiator: RTL



---
 rtl/mem_req_pkg.sv | 27 ++
 rtl/mem_lane_align.sv | 59 +++++
 rtl/mem_req_initiator.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_req_pkg.sv
// Purpose : shared types and constants for the masked-memory request initiator.
// Latency : n/a (package).
// Backpressure: n/a (package).
// Contents: RV32 load/store width codes, initiator FSM states, base byte masks.
package mem_req_pkg;

    // RV32 funct3 width codes for loads/stores; 011, 110 and 111 are illegal.
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte masks for a lane-0 access; shifted left by the address offset.
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/mem_lane_align.sv
// Purpose : sub-word lane handling: legality, byte mask, store shift, load shift/extend.
// Latency : purely combinational, zero cycles.
// Backpressure: none; no handshake, outputs follow inputs.
// Ports   : req_* describe the incoming request (legal, mask, wdata_sh out);
//           rsp_funct3/rsp_off/mem_rdata describe the held load (rdata_ext out).
module mem_lane_align
    import mem_req_pkg::*;
(
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic        legal,
    output logic [3:0]  mask,
    output logic [31:0] wdata_sh,
    input  logic [2:0]  rsp_funct3,
    input  logic [1:0]  rsp_off,
    input  logic [31:0] mem_rdata,
    output logic [31:0] rdata_ext
);

    logic [3:0]  base;
    logic [31:0] lanes;
    logic [31:0] rd_sh;

    // Unsigned widths cannot be stored; halves and words must be naturally aligned.
    always_comb begin
        legal = 1'b0;
        base  = 4'b0000;
        case (req_funct3)
            MEM_B:  begin legal = 1'b1;                       base = MASK_B; end
            MEM_BU: begin legal = !req_we;                    base = MASK_B; end
            MEM_H:  begin legal = !req_off[0];                base = MASK_H; end
            MEM_HU: begin legal = !req_off[0] && !req_we;     base = MASK_H; end
            MEM_W:  begin legal = (req_off == 2'b00);         base = MASK_W; end
            default: begin legal = 1'b0;                      base = 4'b0000; end
        endcase
    end

    assign mask  = base << req_off;
    // Bytes outside the mask are cleared so stray high bits of low-aligned data never leak.
    assign lanes = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    assign wdata_sh = (req_wdata << {req_off, 3'b000}) & lanes;

    assign rd_sh = mem_rdata >> {rsp_off, 3'b000};

    always_comb begin
        rdata_ext = 32'd0;
        case (rsp_funct3)
            MEM_B:   rdata_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            MEM_BU:  rdata_ext = {24'd0, rd_sh[7:0]};
            MEM_H:   rdata_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            MEM_HU:  rdata_ext = {16'd0, rd_sh[15:0]};
            MEM_W:   rdata_ext = rd_sh;
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_req_initiator.sv
// Purpose : turns one CPU load/store into a single masked word transaction on the memory side.
// Latency : rsp_valid N+2 cycles after accept for a mem_resp N cycles after the mask; 1 cycle if illegal.
// Backpressure: req_ready only in IDLE; one outstanding transaction, TIMEOUT aborts a silent memory.
// Ports   : req_* CPU request in, rsp_* one-cycle response out,
//           mem_* masked word interface (addr/rmask/wmask/wdata out, rdata/resp in).
module mem_req_initiator
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  mask_q, mask_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic [15:0] cnt_q, cnt_d;

    logic        req_legal;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata_sh;
    logic [31:0] rdata_ext;
    logic        accept;
    logic        mask_en;
    logic [15:0] cnt_inc;

    mem_lane_align u_align (
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .legal      (req_legal),
        .mask       (req_mask),
        .wdata_sh   (req_wdata_sh),
        .rsp_funct3 (funct3_q),
        .rsp_off    (off_q),
        .mem_rdata  (mem_rdata),
        .rdata_ext  (rdata_ext)
    );

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign cnt_inc   = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d     = req_we;
                    off_d    = req_addr[1:0];
                    funct3_d = req_funct3;
                    if (req_legal) begin
                        addr_d  = {req_addr[31:2], 2'b00};
                        mask_d  = req_mask;
                        wdata_d = req_wdata_sh;
                        cnt_d   = 16'd0;
                        state_d = ST_WAIT;
                    end else begin
                        // Rejected without touching the memory side.
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                        rsp_error_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_resp) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'd0 : rdata_ext;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            mask_q      <= 4'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
            off_q       <= 2'd0;
            funct3_q    <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_error_q <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            cnt_q       <= cnt_d;
        end
    end

    // The responder returns to idle on the mem_resp edge; a mask still visible in that
    // cycle would look like a fresh request, so masks drop combinationally.
    assign mask_en   = (state_q == ST_WAIT) && !mem_resp;
    assign mem_wmask = (mask_en && we_q)  ? mask_q : 4'd0;
    assign mem_rmask = (mask_en && !we_q) ? mask_q : 4'd0;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule
